// File: rtl/vector_pkg.sv
// Shared fixed-point vector types for the RANSAC plane pipeline.
//   single_t : 32-bit signed Q12.20 scalar
//   double_t : 64-bit signed Q24.40 scalar (exact product of two singles)
//   dist_t   : 66-bit signed accumulator for n.p - d, wide enough never to overflow
package vector;

  localparam int unsigned bits_in_single      = 32;
  localparam int unsigned bits_in_double      = 64;
  localparam int unsigned dist_w              = bits_in_double + 2;
  localparam int unsigned inlier_pipe_latency = 3;

  typedef logic signed [bits_in_single-1:0] single_t;
  typedef logic signed [bits_in_double-1:0] double_t;
  typedef logic signed [dist_w-1:0]         dist_t;

  typedef struct packed {
    single_t x;
    single_t y;
    single_t z;
  } vector3s_s;

  typedef vector3s_s point_t;

  typedef struct packed {
    vector3s_s normal;
    double_t   offset;
  } plane_s;

  // Full-precision single x single product; the 64-bit result is exact.
  function automatic double_t mul_ss(input single_t a, input single_t b);
    return double_t'(a) * double_t'(b);
  endfunction

  // Magnitude of a distance; the most negative dist_t value is unreachable.
  function automatic dist_t abs_dist(input dist_t v);
    return v[dist_w-1] ? -v : v;
  endfunction

endpackage

// File: rtl/plane_inlier_counter_distance_pipe.sv
// plane_distance_pipe: 3-stage point-to-plane distance test.
//   clk, rst             : clock, synchronous active-high reset (clears valids)
//   in_valid, point      : accepted point for this cycle
//   normal, offset       : plane n.p = d (held stable during a run)
//   threshold            : inclusive distance limit
//   flag, flag_valid     : registered inlier decision and its valid
//   active_c             : points still in the first two stages
module plane_distance_pipe
  import vector::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  input  point_t    point,
  input  vector3s_s normal,
  input  double_t   offset,
  input  double_t   threshold,
  output logic      flag,
  output logic      flag_valid,
  output logic      active_c
);

  logic [inlier_pipe_latency-1:0] vld;
  double_t prod_x, prod_y, prod_z;
  dist_t   sum;

  // Valid shift chain, one bit per stage.
  always_ff @(posedge clk) begin
    if (rst) vld <= '0;
    else     vld <= {vld[inlier_pipe_latency-2:0], in_valid};
  end

  // Datapath: products, signed sum minus offset, magnitude compare.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      prod_x <= mul_ss(point.x, normal.x);
      prod_y <= mul_ss(point.y, normal.y);
      prod_z <= mul_ss(point.z, normal.z);
    end
    if (vld[0]) sum  <= dist_t'(prod_x) + dist_t'(prod_y) + dist_t'(prod_z) - dist_t'(offset);
    if (vld[1]) flag <= abs_dist(sum) <= dist_t'(threshold);
  end

  assign flag_valid = vld[inlier_pipe_latency-1];
  assign active_c   = |vld[inlier_pipe_latency-2:0];

endmodule

// File: rtl/plane_inlier_counter.sv
// plane_inlier_counter: counts points within threshold of one candidate plane.
//   clk, rst                    : clock, synchronous active-high reset
//   start                       : latch plane/threshold/num_points (IDLE only)
//   plane, threshold, num_points: run parameters
//   point_valid/point_ready/point : point stream handshake
//   busy                        : high in STREAM, DRAIN, DONE
//   done                        : one-cycle pulse, inlier_count final
//   inlier_count                : saturating inlier count
module plane_inlier_counter
  import vector::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  plane_s             plane,
  input  double_t            threshold,
  input  logic [COUNT_W-1:0] num_points,
  input  logic               point_valid,
  output logic               point_ready,
  input  point_t             point,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] inlier_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]         state, state_d;
  plane_s             plane_q;
  double_t            threshold_q;
  logic [COUNT_W-1:0] num_q, accepted;
  logic               point_ready_d, busy_d, done_d;
  logic               accept, last_accept;
  logic               flag, flag_valid, pipe_active_c;

  assign accept      = point_valid && point_ready;
  assign last_accept = accept && (accepted == num_q - COUNT_W'(1));

  plane_distance_pipe u_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (accept),
    .point      (point),
    .normal     (plane_q.normal),
    .offset     (plane_q.offset),
    .threshold  (threshold_q),
    .flag       (flag),
    .flag_valid (flag_valid),
    .active_c   (pipe_active_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (start) state_d = (num_points != '0) ? ST_STREAM : ST_DONE;
      ST_STREAM: if (last_accept) state_d = ST_DRAIN;
      // The flag stage drains in the same cycle the count updates.
      ST_DRAIN:  if (!pipe_active_c) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
    point_ready_d = (state_d == ST_STREAM);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
  end

  // State, outputs, latched run parameters and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      point_ready  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      inlier_count <= '0;
      accepted     <= '0;
      num_q        <= '0;
      threshold_q  <= '0;
      plane_q      <= '0;
    end else begin
      state       <= state_d;
      point_ready <= point_ready_d;
      busy        <= busy_d;
      done        <= done_d;
      if (state == ST_IDLE && start) begin
        plane_q      <= plane;
        threshold_q  <= threshold;
        num_q        <= num_points;
        accepted     <= '0;
        inlier_count <= '0;
      end else begin
        if (accept) accepted <= accepted + COUNT_W'(1);
        if (flag_valid && flag && inlier_count != '1)
          inlier_count <= inlier_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: doc/plane_inlier_counter.md
# plane_inlier_counter

Scores one candidate plane against the point cloud for RANSAC. Takes a plane `n·p = d` from the plane-derivation stage, streams `num_points` points through a 3-stage fixed-point distance pipeline, and counts points with `|n·p − d| <= threshold`. It pulses `done` with the final inlier count for the model-selection stage.

## Interface
- `COUNT_W`, default 16: width of the point-count and inlier-count registers.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; latches the plane, threshold and count. Honoured only in IDLE.
- `plane`  in  `vector::plane_s`  normal (`vector3s_s`) plus offset `d` (`double_t`).
- `threshold`  in  `vector::double_t`  inclusive distance limit; must be ≥ 0.
- `num_points`  in  COUNT_W  number of points to consume.
- `point_valid`  in  1  point stream valid.
- `point_ready`  out  1  point stream ready.
- `point`  in  `vector::point_t`  point, single format.
- `busy`  out  1  high in STREAM, DRAIN and DONE.
- `done`  out  1  one-cycle pulse; `inlier_count` is final.
- `inlier_count`  out  COUNT_W  running count; holds its value from `done` until the next accepted `start`.

## Operation
- States and transitions:
  - IDLE:
    - `start` latches inputs, clears `inlier_count` and the accepted counter.
    - Goes to STREAM if `num_points != 0`, else to DONE.
  - STREAM:
    - `point_ready = 1` while `accepted < num_points`.
    - A point is accepted when `point_valid && point_ready`.
    - Moves to DRAIN in the cycle after the last acceptance.
  - DRAIN: `point_ready = 0`. Waits until all pipeline valid bits are clear and the last count update has happened, then goes to DONE.
  - DONE: `done = 1` for one cycle, then IDLE.
- `start` in any non-IDLE state is ignored. No abort, and no change to latched values.
- Arithmetic:
  - Stage 1: three `single × single` products, full precision, 64 bits each (24.40, exact).
  - Stage 2: sum of the three products minus `d`, sign-extended to 66 bits, so nothing can overflow.
  - Stage 3: absolute value at 66 bits, compared with `threshold` sign-extended to 66 bits. The flag is `abs <= threshold`.
  - No saturation and no truncation anywhere. A large distance is always an outlier and never wraps to small.
- Count: increments on each registered inlier flag. It saturates at `2^COUNT_W − 1`, so it never wraps.
- A `threshold` < 0 is illegal. The result is no inliers, because `abs` is never below 0 in that case.

## Timing
- Reset values: `point_ready = 0`, `busy = 0`, `done = 0`, `inlier_count = 0`, state IDLE, pipeline valids cleared.
- `rst` mid-operation fully aborts. The next cycle is IDLE with every output at its reset value, and `done` is not emitted.
- Point pipeline for a point accepted in cycle t:
  - products registered at the end of t;
  - sum at the end of t+1;
  - flag at the end of t+2;
  - count updated at the end of t+3.
- For the last point accepted in cycle t, `done` is high in cycle t+4 and `inlier_count` already includes that point.
- `num_points = 0`: `start` in cycle s gives `done` in s+1 with count 0.
- `start` in cycle s gives the first `point_ready` in s+1.
- The stream may stall arbitrarily. Throughput is one point per cycle with no bubbles.
- `point_valid` while not ready is not consumed. The source must hold `point` stable until it is accepted.

## Structure
- Additions to `vector`:
  - `plane_s` (packed: `vector3s_s normal; double_t offset`);
  - localparam `inlier_pipe_latency = 3`;
  - localparam `dist_w = bits_in_double + 2`.
- Sub-module `plane_distance_pipe` contains the 3-stage datapath with a valid shift bit and outputs `flag`/`flag_valid`. The top level holds the FSM, counters and stream handshake.

## Test plan
- Inlier/outlier mix:
  - Stimulus: normal (0,0,1.0), d = 0, threshold 0.5; points z = 0.25, −0.5, 0.75, 2.0 (x, y random), back-to-back.
  - Response: `done` 4 cycles after the last acceptance, count 2. The boundary point −0.5 counts as an inlier.
- Empty run: `num_points = 0` → `done` the cycle after `start`, count 0, `point_ready` never high.
- Backpressure:
  - Stimulus: the first scenario repeated with `point_valid` toggling pseudo-randomly.
  - Response: count 2; exactly 4 points accepted; `point_ready` low once 4 are accepted.
- Overflow guard:
  - Stimulus: normal (max, max, max) single, d = min double; points all at max; threshold = max double.
  - Response: count 0. There is no wrap.
- Sign check: normal (1, 1, 1), d = 3.0, point (1, 1, 1), threshold 0 → count 1.
- Control:
  - `start` pulsed in STREAM → ignored; the result matches an uninterrupted run.
  - `rst` asserted after 2 of 4 points → IDLE next cycle, all outputs zero, no `done`.
  - A fresh `start` afterwards completes normally.
